uart_tx_arbiter: RTL

Shares one UART transmitter (the UART_Top tx path: din_tx / data_update / done_tx) between NUM_REQ byte producers.
- Round-robin arbitration; grants one requester per byte, latches its data, drives the transmitter handshake, waits for completion, then inserts a programmable inter-byte gap.
- A watchdog aborts a send that never completes.
- Sits between the producer blocks and UART_Top, in the same clk domain.

---
 rtl/uart_tx_arbiter_pkg.sv | 27 ++
 rtl/uart_tx_arbiter_rr_sel.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// ============================================================================
// Module : uart_tx_arbiter_pkg
// Brief  : Shared FSM encoding, default timing and counter sizing helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int C_DEF_TIMEOUT    = 20000;
    localparam int C_DEF_GAP_CYCLES = 4;

    // Bits needed to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_sel.sv
// ============================================================================
// Module : rr_priority_sel
// Brief  : Combinational round-robin winner search starting after i_ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_priority_sel #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_valid
);

    // Walk from farthest (ptr itself) to nearest (ptr+1) so the nearest hit wins.
    always_comb begin
        int w_idx;
        o_valid  = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        for (int i = N; i >= 1; i--) begin
            w_idx = (int'(i_ptr) + i) % N;
            if (i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = IDX_W'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin sharing of one UART transmitter among NUM_REQ producers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int TIMEOUT    = C_DEF_TIMEOUT,
    parameter int GAP_CYCLES = C_DEF_GAP_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_done,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        timeout_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int WD_W  = cnt_width(TIMEOUT);
    localparam int GAP_W = cnt_width(GAP_CYCLES);
    localparam logic [WD_W-1:0]  C_WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_grant_id;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_tx_start;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_timeout_err;
    logic [WD_W-1:0]     r_wd;
    logic [GAP_W-1:0]    r_gap;
    logic [ID_W-1:0]     w_winner;
    logic                w_valid;
    logic                w_wd_term;
    logic                w_gap_term;
    logic                w_send_end;

    rr_priority_sel #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_sel (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    assign w_wd_term  = (r_wd == C_WD_LAST);
    assign w_gap_term = (r_gap == C_GAP_LAST);
    // A completion arriving on the terminal count wins over the abort.
    assign w_send_end = (r_state == SEND) && (tx_done || w_wd_term);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_state_next = LATCH;
            LATCH:   w_state_next = SEND;
            SEND:    if (w_send_end) w_state_next = GAP;
            GAP:     if (w_gap_term) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr         <= ID_W'(NUM_REQ - 1);
            r_grant_id    <= '0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_ack         <= '0;
            r_timeout_err <= 1'b0;
            r_wd          <= '0;
            r_gap         <= '0;
        end else begin
            r_ack         <= '0;
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_grant_id <= w_winner;
                        r_ptr      <= w_winner;
                    end
                end
                LATCH: begin
                    r_tx_data  <= req_data[int'(r_grant_id)*DATA_W +: DATA_W];
                    r_wd       <= '0;
                    r_tx_start <= 1'b1;
                end
                SEND: begin
                    if (w_send_end) begin
                        r_tx_start    <= 1'b0;
                        r_ack         <= NUM_REQ'(1) << r_grant_id;
                        r_timeout_err <= !tx_done;
                        r_gap         <= '0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                GAP: begin
                    if (!w_gap_term) begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack         = r_ack;
    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign busy        = (r_state != IDLE);
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire
